floo_reduction_collector: RTL

// Buffered, fully handshaked successor of the combinational B-response reduction arbiter.

---
 rtl/floo_reduction_collector.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/floo_reduction_collector.sv
// Buffered B-response reduction collector: holds one flit per route, gathers a
// multicast response group, reduces RESP by severity and emits one flit.

package floo_reduction_pkg;

  typedef enum logic [3:0] {
    NarrowAw = 4'd0,
    NarrowW  = 4'd1,
    NarrowAr = 4'd2,
    NarrowB  = 4'd3,
    NarrowR  = 4'd4,
    WideAw   = 4'd5,
    WideW    = 4'd6,
    WideAr   = 4'd7,
    WideB    = 4'd8,
    WideR    = 4'd9
  } axi_ch_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } axi_resp_e;

  typedef struct packed {
    axi_ch_e    axi_ch;
    logic [3:0] src_id;
  } hdr_t;

  typedef logic [31:0] payload_t;

  typedef struct packed {
    hdr_t     hdr;
    payload_t payload;
  } flit_t;

endpackage

module floo_reduction_collector #(
  parameter int unsigned NumRoutes     = 5,
  parameter type         flit_t        = floo_reduction_pkg::flit_t,
  parameter type         payload_t     = floo_reduction_pkg::payload_t,
  parameter payload_t    NarrowRspMask = '0,
  parameter payload_t    WideRspMask   = '0,
  parameter bit          EnTimeout     = 1'b1,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumRoutes-1:0] valid_i,
  output logic [NumRoutes-1:0] ready_o,
  input  flit_t [NumRoutes-1:0] data_i,
  output flit_t                leader_o,
  input  logic [NumRoutes-1:0] exp_mask_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output flit_t                data_o,
  output logic                 timeout_o
);

  localparam int unsigned PayloadW = $bits(payload_t);
  localparam int unsigned CntW     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  // Bit position of the lowest set bit of a RESP mask (0 for an empty mask).
  function automatic int unsigned lsb_idx(payload_t m);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < PayloadW; i++) begin
      if (m[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  localparam int unsigned NarrowOff = lsb_idx(NarrowRspMask);
  localparam int unsigned WideOff   = lsb_idx(WideRspMask);

  // Extract the 2-bit RESP field at the channel-dependent offset.
  function automatic logic [1:0] get_resp(flit_t f, logic narrow);
    payload_t sh;
    sh = narrow ? (f.payload >> NarrowOff) : (f.payload >> WideOff);
    return sh[1:0];
  endfunction

  // Overwrite the 2-bit RESP field at the channel-dependent offset.
  function automatic flit_t set_resp(flit_t f, logic narrow, logic [1:0] resp);
    payload_t fld;
    payload_t val;
    fld = narrow ? (payload_t'(2'b11) << NarrowOff) : (payload_t'(2'b11) << WideOff);
    val = narrow ? (payload_t'(resp) << NarrowOff) : (payload_t'(resp) << WideOff);
    f.payload = (f.payload & ~fld) | val;
    return f;
  endfunction

  // Severity rank: DECERR > SLVERR > OKAY > EXOKAY.
  function automatic logic [1:0] sev_rank(logic [1:0] resp);
    logic [1:0] r;
    case (resp)
      2'b11:   r = 2'd3;
      2'b10:   r = 2'd2;
      2'b00:   r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StEmit    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NumRoutes-1:0] held_q, held_d;
  logic [NumRoutes-1:0] drop_q, drop_d;
  logic [NumRoutes-1:0] lead_oh_q, lead_oh_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  flit_t                leader_q, leader_d;
  flit_t                data_q, data_d;
  logic                 valid_q, valid_d;
  flit_t                buf_q [NumRoutes];

  logic [NumRoutes-1:0] cap;
  logic [NumRoutes-1:0] drop_acc;
  logic [NumRoutes-1:0] eff_mask;
  logic [NumRoutes-1:0] grp_all;
  logic                 grp_done;
  logic                 timeout_c;
  flit_t                red_flit;

  // Per-route accept decision, group completion and timeout detection.
  always_comb begin
    logic found;
    cap       = '0;
    found     = 1'b0;
    drop_acc  = valid_i & drop_q;
    eff_mask  = exp_mask_i | lead_oh_q;
    grp_all   = held_q;
    grp_done  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      StIdle: begin
        for (int unsigned i = 0; i < NumRoutes; i++) begin
          if (valid_i[i] && !drop_q[i] && !found) begin
            cap[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
      StCollect: begin
        cap       = valid_i & eff_mask & ~held_q & ~drop_q;
        grp_all   = held_q | cap;
        grp_done  = (grp_all == eff_mask);
        timeout_c = EnTimeout && !grp_done && (cnt_q == CntMax);
      end
      default: ;
    endcase
  end

  // Worst-RESP selection over the group members, lowest index wins ties.
  always_comb begin
    logic       narrow;
    logic       found;
    logic [1:0] best_rank;
    logic [1:0] rank;
    flit_t      src;
    narrow    = (leader_q.hdr.axi_ch == floo_reduction_pkg::NarrowB);
    found     = 1'b0;
    best_rank = '0;
    rank      = '0;
    src       = '0;
    red_flit  = '0;
    for (int unsigned i = 0; i < NumRoutes; i++) begin
      src  = cap[i] ? data_i[i] : buf_q[i];
      rank = sev_rank(get_resp(src, narrow));
      if (grp_all[i] && (!found || (rank > best_rank))) begin
        found     = 1'b1;
        best_rank = rank;
        red_flit  = src;
      end
    end
    if (timeout_c) begin
      red_flit = set_resp(red_flit, narrow, 2'b10);
    end
  end

  // Next-state and register updates of the collector FSM.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    drop_d    = drop_q & ~drop_acc;
    lead_oh_d = lead_oh_q;
    cnt_d     = cnt_q;
    leader_d  = leader_q;
    data_d    = data_q;
    valid_d   = valid_q;
    case (state_q)
      StIdle: begin
        if (|cap) begin
          held_d    = cap;
          lead_oh_d = cap;
          cnt_d     = '0;
          state_d   = StCollect;
          for (int unsigned i = 0; i < NumRoutes; i++) begin
            if (cap[i]) leader_d = data_i[i];
          end
        end
      end
      StCollect: begin
        held_d = grp_all;
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        if (timeout_c) drop_d = drop_d | (eff_mask & ~grp_all);
        if (grp_done || timeout_c) begin
          state_d = StEmit;
          valid_d = 1'b1;
          data_d  = red_flit;
        end
      end
      StEmit: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          held_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      held_q    <= '0;
      drop_q    <= '0;
      lead_oh_q <= '0;
      cnt_q     <= '0;
      leader_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      drop_q    <= drop_d;
      lead_oh_q <= lead_oh_d;
      cnt_q     <= cnt_d;
      leader_q  <= leader_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // Per-route flit buffers, written on every captured flit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRoutes; i++) buf_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NumRoutes; i++) begin
        if (cap[i]) buf_q[i] <= data_i[i];
      end
    end
  end

  // Accepts and the timeout pulse are forced low while reset is held.
  assign ready_o   = rst_i ? '0 : (cap | drop_acc);
  assign timeout_o = timeout_c & ~rst_i;
  assign leader_o  = leader_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;

endmodule
